// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall/flush and WB->store-data forwarding.
// Optional alignment trap for loads/stores: define MISALIGN_TRAP_EN.
module ex_mem_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              EX_valid,
    input  logic [DATA_W-1:0] EX_ALU_out,
    input  logic [DATA_W-1:0] EX_RegB,
    input  logic [REG_W-1:0]  EX_Rt,
    input  logic [REG_W-1:0]  EX_Write_register,
    input  logic              EX_MemRead,
    input  logic              EX_MemWrite,
    input  logic              EX_RegWrite,
    input  logic [1:0]        EX_MemtoReg,
    input  logic [DATA_W-1:0] EX_PC_plus4,
    input  logic              WB_RegWrite,
    input  logic [REG_W-1:0]  WB_Write_register,
    input  logic [DATA_W-1:0] WB_data,
    output logic              MEM_valid,
    output logic [DATA_W-1:0] MEM_ALU_out,
    output logic [DATA_W-1:0] MEM_RegB,
    output logic [REG_W-1:0]  MEM_Write_register,
    output logic              MEM_MemRead,
    output logic              MEM_MemWrite,
    output logic              MEM_RegWrite,
    output logic [1:0]        MEM_MemtoReg,
    output logic [DATA_W-1:0] MEM_PC_plus4,
    output logic              misalign_exc,
    output logic [DATA_W-1:0] misalign_addr
);

    logic              r_valid;
    logic [DATA_W-1:0] r_alu;
    logic [DATA_W-1:0] r_regb;
    logic [REG_W-1:0]  r_rt;
    logic [REG_W-1:0]  r_wr;
    logic              r_mr;
    logic              r_mw;
    logic              r_rw;
    logic [1:0]        r_mtr;
    logic [DATA_W-1:0] r_pc4;

    logic              w_mis;
    logic              w_capture;
    logic              w_fwd;

    assign w_capture = ~flush & ~stall;

`ifdef MISALIGN_TRAP_EN
    assign w_mis = EX_valid & (EX_MemRead | EX_MemWrite)
                 & (EX_ALU_out[1:0] != 2'b00);
`else
    assign w_mis = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_alu   <= '0;
            r_regb  <= '0;
            r_rt    <= '0;
            r_wr    <= '0;
            r_mr    <= 1'b0;
            r_mw    <= 1'b0;
            r_rw    <= 1'b0;
            r_mtr   <= 2'b00;
            r_pc4   <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_alu   <= '0;
            r_regb  <= '0;
            r_rt    <= '0;
            r_wr    <= '0;
            r_mr    <= 1'b0;
            r_mw    <= 1'b0;
            r_rw    <= 1'b0;
            r_mtr   <= 2'b00;
            r_pc4   <= '0;
        end else if (!stall) begin
            // A trapped access stays valid but loses all side effects.
            r_valid <= EX_valid;
            r_alu   <= EX_ALU_out;
            r_regb  <= EX_RegB;
            r_rt    <= EX_Rt;
            r_wr    <= EX_Write_register;
            r_mr    <= EX_MemRead  & EX_valid & ~w_mis;
            r_mw    <= EX_MemWrite & EX_valid & ~w_mis;
            r_rw    <= EX_RegWrite & EX_valid & ~w_mis;
            r_mtr   <= EX_MemtoReg;
            r_pc4   <= EX_PC_plus4;
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic              r_exc;
    logic [DATA_W-1:0] r_addr;

    // The pulse drops on any non-capture edge; the address is sticky.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_exc  <= 1'b0;
            r_addr <= '0;
        end else begin
            r_exc <= w_capture & w_mis;
            if (w_capture && w_mis) begin
                r_addr <= EX_ALU_out;
            end
        end
    end

    assign misalign_exc  = r_exc;
    assign misalign_addr = r_addr;
`else
    assign misalign_exc  = 1'b0;
    assign misalign_addr = '0;
`endif

    // Register 0 never forwards.
    assign w_fwd = r_mw & WB_RegWrite
                 & (WB_Write_register != '0)
                 & (WB_Write_register == r_rt);

    assign MEM_valid          = r_valid;
    assign MEM_ALU_out        = r_alu;
    assign MEM_RegB           = w_fwd ? WB_data : r_regb;
    assign MEM_Write_register = r_wr;
    assign MEM_MemRead        = r_mr;
    assign MEM_MemWrite       = r_mw;
    assign MEM_RegWrite       = r_rw;
    assign MEM_MemtoReg       = r_mtr;
    assign MEM_PC_plus4       = r_pc4;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Scoreboard bench for ex_mem_reg: directed plan items plus random traffic.
// Expected values come from a rule-level model of the pipeline register.
module tb_ex_mem_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        EX_valid;
    logic [31:0] EX_ALU_out;
    logic [31:0] EX_RegB;
    logic [4:0]  EX_Rt;
    logic [4:0]  EX_Write_register;
    logic        EX_MemRead;
    logic        EX_MemWrite;
    logic        EX_RegWrite;
    logic [1:0]  EX_MemtoReg;
    logic [31:0] EX_PC_plus4;
    logic        WB_RegWrite;
    logic [4:0]  WB_Write_register;
    logic [31:0] WB_data;
    logic        MEM_valid;
    logic [31:0] MEM_ALU_out;
    logic [31:0] MEM_RegB;
    logic [4:0]  MEM_Write_register;
    logic        MEM_MemRead;
    logic        MEM_MemWrite;
    logic        MEM_RegWrite;
    logic [1:0]  MEM_MemtoReg;
    logic [31:0] MEM_PC_plus4;
    logic        misalign_exc;
    logic [31:0] misalign_addr;

    ex_mem_reg #(.DATA_W(32), .REG_W(5)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .EX_valid(EX_valid), .EX_ALU_out(EX_ALU_out),
        .EX_RegB(EX_RegB), .EX_Rt(EX_Rt),
        .EX_Write_register(EX_Write_register),
        .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
        .EX_RegWrite(EX_RegWrite), .EX_MemtoReg(EX_MemtoReg),
        .EX_PC_plus4(EX_PC_plus4), .WB_RegWrite(WB_RegWrite),
        .WB_Write_register(WB_Write_register), .WB_data(WB_data),
        .MEM_valid(MEM_valid), .MEM_ALU_out(MEM_ALU_out),
        .MEM_RegB(MEM_RegB), .MEM_Write_register(MEM_Write_register),
        .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
        .MEM_RegWrite(MEM_RegWrite), .MEM_MemtoReg(MEM_MemtoReg),
        .MEM_PC_plus4(MEM_PC_plus4), .misalign_exc(misalign_exc),
        .misalign_addr(misalign_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] alu;
        logic [31:0] regb;
        logic [4:0]  rt;
        logic [4:0]  wr;
        logic        mr;
        logic        mw;
        logic        rw;
        logic [1:0]  mtr;
        logic [31:0] pc4;
        logic        exc;
        logic [31:0] addr;
    } rec_t;

    rec_t m;
    rec_t q[$];
    int   total = 0;
    int   bad   = 0;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic rec_t zero_rec();
        rec_t z;
        z = '{default: '0};
        return z;
    endfunction

    // Architectural view: a bubble, a frozen slot, or the EX instruction
    // as seen by MEM (side effects only for real, well-aligned accesses).
    task automatic model_edge();
        logic trap;
        if (flush) begin
            logic [31:0] keep;
            keep = m.addr;
            m = zero_rec();
            m.addr = keep;
        end else if (stall) begin
            m.exc = 1'b0;
        end else begin
            trap = TRAP && EX_valid && (EX_MemRead || EX_MemWrite)
                   && (EX_ALU_out % 4 != 0);
            m.valid = EX_valid;
            m.alu   = EX_ALU_out;
            m.regb  = EX_RegB;
            m.rt    = EX_Rt;
            m.wr    = EX_Write_register;
            m.mr    = EX_valid && EX_MemRead && !trap;
            m.mw    = EX_valid && EX_MemWrite && !trap;
            m.rw    = EX_valid && EX_RegWrite && !trap;
            m.mtr   = EX_MemtoReg;
            m.pc4   = EX_PC_plus4;
            m.exc   = trap;
            if (trap) m.addr = EX_ALU_out;
        end
    endtask

    function automatic logic [31:0] store_data(rec_t r);
        if (r.mw && WB_RegWrite && WB_Write_register != 0
            && WB_Write_register == r.rt)
            return WB_data;
        return r.regb;
    endfunction

    task automatic tick();
        rec_t e;
        @(posedge clk);
        model_edge();
        e = m;
        e.regb = store_data(m);
        q.push_back(e);
        #2;
    endtask

    initial begin : monitor
        rec_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("sb_valid", 32'(MEM_valid), 32'(e.valid));
                chk("sb_alu", MEM_ALU_out, e.alu);
                chk("sb_regb", MEM_RegB, e.regb);
                chk("sb_wr", 32'(MEM_Write_register), 32'(e.wr));
                chk("sb_mr", 32'(MEM_MemRead), 32'(e.mr));
                chk("sb_mw", 32'(MEM_MemWrite), 32'(e.mw));
                chk("sb_rw", 32'(MEM_RegWrite), 32'(e.rw));
                chk("sb_mtr", 32'(MEM_MemtoReg), 32'(e.mtr));
                chk("sb_pc4", MEM_PC_plus4, e.pc4);
                chk("sb_exc", 32'(misalign_exc), 32'(e.exc));
                chk("sb_addr", misalign_addr, e.addr);
            end
        end
    end

    task automatic idle_ex();
        stall = 0; flush = 0; EX_valid = 0;
        EX_ALU_out = 0; EX_RegB = 0; EX_Rt = 0;
        EX_Write_register = 0; EX_MemRead = 0; EX_MemWrite = 0;
        EX_RegWrite = 0; EX_MemtoReg = 0; EX_PC_plus4 = 0;
        WB_RegWrite = 0; WB_Write_register = 0; WB_data = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(MEM_valid), 0);
        chk({tag, "_alu"}, MEM_ALU_out, 0);
        chk({tag, "_regb"}, MEM_RegB, 0);
        chk({tag, "_mw"}, 32'(MEM_MemWrite), 0);
        chk({tag, "_mr"}, 32'(MEM_MemRead), 0);
        chk({tag, "_rw"}, 32'(MEM_RegWrite), 0);
        chk({tag, "_pc4"}, MEM_PC_plus4, 0);
        chk({tag, "_exc"}, 32'(misalign_exc), 0);
        chk({tag, "_addr"}, misalign_addr, 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        idle_ex();
        reset = 0;
        m = zero_rec();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1;

        // Normal load capture
        EX_valid = 1; EX_ALU_out = 32'h10; EX_MemRead = 1;
        EX_Write_register = 5'd3; EX_RegWrite = 1; EX_MemtoReg = 2'd1;
        EX_PC_plus4 = 32'h104;
        tick();
        chk("load_alu", MEM_ALU_out, 32'h10);
        chk("load_mr", 32'(MEM_MemRead), 1);

        // Stall two cycles with new EX contents
        @(negedge clk);
        stall = 1; EX_ALU_out = 32'h999; EX_MemRead = 0; EX_MemWrite = 1;
        tick();
        @(negedge clk);
        EX_ALU_out = 32'h777;
        tick();
        chk("stall_alu", MEM_ALU_out, 32'h10);
        chk("stall_mr", 32'(MEM_MemRead), 1);
        chk("stall_mw", 32'(MEM_MemWrite), 0);

        // Store captured, then flush overriding stall
        @(negedge clk);
        stall = 0; EX_ALU_out = 32'h20; EX_MemWrite = 1; EX_RegWrite = 0;
        tick();
        chk("store_mw", 32'(MEM_MemWrite), 1);
        @(negedge clk);
        stall = 1; flush = 1;
        tick();
        chk("flush_valid", 32'(MEM_valid), 0);
        chk("flush_mw", 32'(MEM_MemWrite), 0);

        // Load->store forward via r8, then r0 which must not forward
        @(negedge clk);
        stall = 0; flush = 0; EX_ALU_out = 32'h40; EX_Rt = 5'd8;
        EX_RegB = 32'h11111111;
        WB_RegWrite = 1; WB_Write_register = 5'd8; WB_data = 32'hDEADBEEF;
        tick();
        chk("fwd_r8", MEM_RegB, 32'hDEADBEEF);
        @(negedge clk);
        EX_Rt = 5'd0; WB_Write_register = 5'd0;
        tick();
        chk("fwd_r0", MEM_RegB, 32'h11111111);

        // Misaligned store
        @(negedge clk);
        WB_RegWrite = 0; EX_ALU_out = 32'h102;
        tick();
        chk("mis_mw", 32'(MEM_MemWrite), TRAP ? 0 : 1);
        chk("mis_exc", 32'(misalign_exc), TRAP ? 1 : 0);
        chk("mis_addr", misalign_addr, TRAP ? 32'h102 : 0);
        chk("mis_valid", 32'(MEM_valid), 1);
        @(negedge clk);
        EX_ALU_out = 32'h200;
        tick();
        chk("mis_pulse_end", 32'(misalign_exc), 0);

        // Invalid instruction cannot write back
        @(negedge clk);
        EX_valid = 0; EX_RegWrite = 1; EX_MemWrite = 0;
        tick();
        chk("inv_rw", 32'(MEM_RegWrite), 0);
        chk("inv_valid", 32'(MEM_valid), 0);

        // Async reset mid-cycle with a store sitting in MEM
        @(negedge clk);
        EX_valid = 1; EX_MemWrite = 1; EX_ALU_out = 32'h80;
        tick();
        chk("pre_rst_mw", 32'(MEM_MemWrite), 1);
        #1 reset = 0;
        m = zero_rec();
        #1 check_all_zero("async_rst");
        @(negedge clk);
        reset = 1;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            stall             = ($urandom_range(3) == 0);
            flush             = ($urandom_range(7) == 0);
            EX_valid          = ($urandom_range(4) != 0);
            EX_ALU_out        = $urandom;
            EX_RegB           = $urandom;
            EX_Rt             = 5'($urandom_range(7));
            EX_Write_register = 5'($urandom);
            EX_MemRead        = 1'($urandom);
            EX_MemWrite       = 1'($urandom);
            EX_RegWrite       = 1'($urandom);
            EX_MemtoReg       = 2'($urandom_range(2));
            EX_PC_plus4       = $urandom;
            WB_RegWrite       = 1'($urandom);
            WB_Write_register = 5'($urandom_range(7));
            WB_data           = $urandom;
            tick();
        end

        @(negedge clk);
        chk("sb_drained", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
